// File: rtl/pipe_stall_if.sv
// Front-end pipeline control bundle: hazard/bus inputs from ID, EX and MEM, and the
// enable/flush controls for the PC, IF/ID and ID/EX register banks.
interface pipe_stall_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rt;
    logic       ex_mem_read;
    logic       jump_taken;
    logic       mem_req;
    logic       bus_ready;
    logic       pc_ena;
    logic       ifid_ena;
    logic       ifid_flush;
    logic       idex_flush;
    logic       bus_timeout;

    modport master (
        output id_rs, id_rt, ex_rt, ex_mem_read, jump_taken, mem_req, bus_ready,
        input  pc_ena, ifid_ena, ifid_flush, idex_flush, bus_timeout
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_mem_read, jump_taken, mem_req, bus_ready,
        output pc_ena, ifid_ena, ifid_flush, idex_flush, bus_timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the PC, IF/ID and ID/EX registers: bus wait > load-use > jump.
// Optional performance counters are built when STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_if.slave       pipe_if
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]       perf_bus_stall,
    output logic [31:0]       perf_load_use,
    output logic [31:0]       perf_jump
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUS_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // Control vector order: {pc_ena, ifid_ena, ifid_flush, idex_flush}
    localparam logic [3:0] CTRL_FREEZE = 4'b0000;
    localparam logic [3:0] CTRL_RESET  = 4'b0011;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_timeout_q, bus_timeout_d;

    logic             load_use;
    logic             bus_stall;
    logic             bus_freeze;
    logic [3:0]       ctrl;

    function automatic logic [3:0] run_decode(input logic lu, input logic jt);
        logic [3:0] c;
        if (lu) begin
            c = 4'b0001;
        end else if (jt) begin
            c = 4'b1110;
        end else begin
            c = 4'b1100;
        end
        return c;
    endfunction

    assign load_use  = pipe_if.ex_mem_read && (pipe_if.ex_rt != 5'd0) &&
                       ((pipe_if.ex_rt == pipe_if.id_rs) || (pipe_if.ex_rt == pipe_if.id_rt));
    assign bus_stall = pipe_if.mem_req && !pipe_if.bus_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        bus_timeout_d = bus_timeout_q;
        bus_freeze    = 1'b0;
        ctrl          = run_decode(load_use, pipe_if.jump_taken);

        case (state_q)
            RUN: begin
                if (bus_stall) begin
                    ctrl       = CTRL_FREEZE;
                    bus_freeze = 1'b1;
                    state_d    = BUS_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            BUS_WAIT: begin
                if (!pipe_if.bus_ready) begin
                    ctrl       = CTRL_FREEZE;
                    bus_freeze = 1'b1;
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                    if ((TIMEOUT != 0) && (wait_cnt_q >= CNT_LAST)) begin
                        state_d       = ERR;
                        bus_timeout_d = 1'b1;
                    end
                end else begin
                    // Ready cycle releases in the same cycle with the normal hazard decode
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                ctrl    = CTRL_FREEZE;
                state_d = RUN;
            end
        endcase

        if (rst) begin
            ctrl       = CTRL_RESET;
            bus_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign pipe_if.pc_ena      = ctrl[3];
    assign pipe_if.ifid_ena    = ctrl[2];
    assign pipe_if.ifid_flush  = ctrl[1];
    assign pipe_if.idex_flush  = ctrl[0];
    assign pipe_if.bus_timeout = bus_timeout_q;

`ifdef STALL_PERF_EN
    logic [31:0] perf_bus_q, perf_lu_q, perf_jmp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bus_q <= '0;
            perf_lu_q  <= '0;
            perf_jmp_q <= '0;
        end else begin
            if (bus_freeze) begin
                perf_bus_q <= perf_bus_q + 32'd1;
            end
            if (ctrl[0]) begin
                perf_lu_q <= perf_lu_q + 32'd1;
            end
            if (ctrl[1]) begin
                perf_jmp_q <= perf_jmp_q + 32'd1;
            end
        end
    end

    assign perf_bus_stall = perf_bus_q;
    assign perf_load_use  = perf_lu_q;
    assign perf_jump      = perf_jmp_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: one instance with TIMEOUT=4 and one with the
// timeout disabled and a narrow counter, both fed the same stimulus.
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pipe_stall_if if4 ();
    pipe_stall_if if0 ();

    assign if0.id_rs       = if4.id_rs;
    assign if0.id_rt       = if4.id_rt;
    assign if0.ex_rt       = if4.ex_rt;
    assign if0.ex_mem_read = if4.ex_mem_read;
    assign if0.jump_taken  = if4.jump_taken;
    assign if0.mem_req     = if4.mem_req;
    assign if0.bus_ready   = if4.bus_ready;

`ifdef STALL_PERF_EN
    logic [31:0] pb4, pl4, pj4, pb0, pl0, pj0;
`endif

    pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(8)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .pipe_if (if4.slave)
`ifdef STALL_PERF_EN
        ,
        .perf_bus_stall (pb4),
        .perf_load_use  (pl4),
        .perf_jump      (pj4)
`endif
    );

    pipe_stall_ctrl #(.TIMEOUT(0), .CNT_W(3)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .pipe_if (if0.slave)
`ifdef STALL_PERF_EN
        ,
        .perf_bus_stall (pb0),
        .perf_load_use  (pl0),
        .perf_jump      (pj0)
`endif
    );

    wire [3:0] ctrl4 = {if4.pc_ena, if4.ifid_ena, if4.ifid_flush, if4.idex_flush};
    wire [3:0] ctrl0 = {if0.pc_ena, if0.ifid_ena, if0.ifid_flush, if0.idex_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                         input logic mr, input logic jt, input logic mq, input logic br);
        @(negedge clk);
        if4.id_rs       = rs;
        if4.id_rt       = rt;
        if4.ex_rt       = ert;
        if4.ex_mem_read = mr;
        if4.jump_taken  = jt;
        if4.mem_req     = mq;
        if4.bus_ready   = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("reset_ctrl", ctrl4, 4'b0011);
        tick();
        chk("reset_timeout", if4.bus_timeout, 0);
        chk("reset_state", u_dut4.state_q, 0);
        chk("reset_cnt", u_dut4.wait_cnt_q, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("idle", ctrl4, 4'b1100);

        // Load-use on rs, then clear
        drive(8, 1, 8, 1, 0, 0, 0);
        chk("lu_rs", ctrl4, 4'b0001);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu_rs_after", ctrl4, 4'b1100);
        // Load-use on rt
        drive(3, 8, 8, 1, 0, 0, 0);
        chk("lu_rt", ctrl4, 4'b0001);
        // r0 never hazards
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("lu_r0", ctrl4, 4'b1100);
        // Matching regs without a load
        drive(8, 8, 8, 0, 0, 0, 0);
        chk("no_load", ctrl4, 4'b1100);
        // Jump alone
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("jump", ctrl4, 4'b1110);
        // Jump + load-use: load-use wins, jump next cycle
        drive(8, 0, 8, 1, 1, 0, 0);
        chk("jump_lu", ctrl4, 4'b0001);
        drive(8, 0, 8, 0, 1, 0, 0);
        chk("jump_after_lu", ctrl4, 4'b1110);
        // Bus access completing immediately: no stall
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("bus_ready_now", ctrl4, 4'b1100);

        // 3-cycle bus wait, with hazards present that must be overridden
        drive(8, 0, 8, 1, 1, 1, 0);
        chk("bus_w1", ctrl4, 4'b0000);
        tick();
        chk("bus_w1_state", u_dut4.state_q, 1);
        chk("bus_w1_cnt", u_dut4.wait_cnt_q, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("bus_w2", ctrl4, 4'b0000);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("bus_w3", ctrl4, 4'b0000);
        drive(0, 0, 0, 0, 1, 1, 1);
        chk("bus_release", ctrl4, 4'b1110);
        tick();
        chk("bus_release_state", u_dut4.state_q, 0);
        chk("bus_release_cnt", u_dut4.wait_cnt_q, 0);
        chk("bus_release_to", if4.bus_timeout, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("post_bus_idle", ctrl4, 4'b1100);
`ifdef STALL_PERF_EN
        chk("perf_bus", pb4, 3);
        chk("perf_lu", pl4, 3);
        chk("perf_jump", pj4, 3);
`endif

        // Timeout: 4 wait edges into ERR on the TIMEOUT=4 instance
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("to_freeze%0d", i), ctrl4, 4'b0000);
            tick();
            chk($sformatf("to_flag%0d", i), if4.bus_timeout, (i == 4) ? 1 : 0);
        end
        chk("to_state_err", u_dut4.state_q, 2);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        chk("nto_state", u_dut0.state_q, 1);
        chk("nto_cnt_sat", u_dut0.wait_cnt_q, 7);
        chk("nto_flag", if0.bus_timeout, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("err_freeze", ctrl4, 4'b0000);
        chk("err_flag_sticky", if4.bus_timeout, 1);
        chk("nto_release", ctrl0, 4'b1100);
        tick();
        chk("err_stays", u_dut4.state_q, 2);
        chk("nto_run", u_dut0.state_q, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("err_rst_ctrl", ctrl4, 4'b0011);
        tick();
        chk("err_rst_flag", if4.bus_timeout, 0);
        chk("err_rst_state", u_dut4.state_q, 0);
        rst = 1'b0;

        // Reset asserted mid bus wait
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("bw_cnt2", u_dut4.wait_cnt_q, 2);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("bw_rst_ctrl", ctrl4, 4'b0011);
        tick();
        chk("bw_rst_state", u_dut4.state_q, 0);
        chk("bw_rst_cnt", u_dut4.wait_cnt_q, 0);
`ifdef STALL_PERF_EN
        chk("bw_rst_pb", pb4, 0);
        chk("bw_rst_pl", pl4, 0);
        chk("bw_rst_pj", pj4, 0);
`endif
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("bw_after_rst", ctrl4, 4'b1100);
        tick();
        chk("bw_after_state", u_dut4.state_q, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
